// File: rtl/glyph_renderer.sv
// Text-box overlay for a VGA pixel stream: looks up glyph rows in an external 32x32 font ROM
// and re-times the sync/video signals so everything leaves aligned, two clocks after pixel_x/pixel_y.
module glyph_renderer #(
    parameter int          NUM_CHARS = 4,
    parameter logic [9:0]  X0        = 10'd64,
    parameter logic [9:0]  Y0        = 10'd64,
    parameter logic [11:0] FG_RGB    = 12'hFFF,
    parameter logic [11:0] BG_RGB    = 12'h000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic                   video_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [2*NUM_CHARS-1:0] text_in,
    input  logic                   upd_req,
    output logic                   upd_ack,
    output logic [6:0]             rom_addr,
    input  logic [31:0]            rom_data,
    output logic                   pixel_on,
    output logic [11:0]            rgb,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   video_on_out
);

    localparam int          IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int          DX_W  = 5 + IDX_W;
    localparam logic [10:0] X_END = 11'(X0) + 11'(32 * NUM_CHARS);
    localparam logic [10:0] Y_END = 11'(Y0) + 11'd32;
    localparam logic [1:0]  BLANK_CODE = 2'b11;

    logic [2*NUM_CHARS-1:0] text_q, text_d;
    logic                   upd_ack_q, upd_ack_d;
    logic                   vsync_prev_q;
    logic                   frame_start;

    logic [DX_W-1:0]        dx;
    logic [4:0]             row;
    logic [IDX_W-1:0]       idx;
    logic [1:0]             code;
    logic                   in_box;

    logic [4:0]             col_p1_q, col_p1_d;
    logic                   in_box_p1_q, in_box_p1_d;
    logic                   blank_p1_q, blank_p1_d;
    logic                   video_p1_q, video_p1_d;
    logic                   hsync_p1_q, hsync_p1_d;
    logic                   vsync_p1_q, vsync_p1_d;

    logic                   pixel_on_q, pixel_on_d;
    logic [11:0]            rgb_q, rgb_d;
    logic                   hsync_p2_q, hsync_p2_d;
    logic                   vsync_p2_q, vsync_p2_d;
    logic                   video_p2_q, video_p2_d;

    // Text register only ever changes on the vsync falling edge, so a frame never tears.
    always_comb begin
        frame_start = vsync_prev_q & ~vsync_in;
        text_d      = text_q;
        upd_ack_d   = 1'b0;
        if (frame_start && upd_req) begin
            text_d    = text_in;
            upd_ack_d = 1'b1;
        end
    end

    // Stage 0: box decode and ROM address; compares are 11 bits wide so X_END cannot wrap.
    always_comb begin
        dx     = pixel_x[DX_W-1:0] - X0[DX_W-1:0];
        row    = pixel_y[4:0] - Y0[4:0];
        idx    = dx[5 +: IDX_W];
        in_box = ({1'b0, pixel_x} >= 11'(X0)) && ({1'b0, pixel_x} < X_END) &&
                 ({1'b0, pixel_y} >= 11'(Y0)) && ({1'b0, pixel_y} < Y_END);
        code   = BLANK_CODE;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (idx == IDX_W'(i)) begin
                code = text_q[2*i +: 2];
            end
        end
        rom_addr = in_box ? {code, row} : 7'h00;
    end

    // Stage 1: carry per-pixel context alongside the ROM read
    always_comb begin
        col_p1_d    = dx[4:0];
        in_box_p1_d = in_box;
        blank_p1_d  = (code == BLANK_CODE);
        video_p1_d  = video_on;
        hsync_p1_d  = hsync_in;
        vsync_p1_d  = vsync_in;
    end

    // Stage 2: ROM row is now valid; pick the column bit (bit 31 is the leftmost pixel)
    always_comb begin
        pixel_on_d = video_p1_q & in_box_p1_q & ~blank_p1_q & rom_data[5'd31 - col_p1_q];
        rgb_d      = video_p1_q ? (pixel_on_d ? FG_RGB : BG_RGB) : 12'h000;
        hsync_p2_d = hsync_p1_q;
        vsync_p2_d = vsync_p1_q;
        video_p2_d = video_p1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_q       <= '1;
            upd_ack_q    <= 1'b0;
            vsync_prev_q <= 1'b1;
            col_p1_q     <= 5'd0;
            in_box_p1_q  <= 1'b0;
            blank_p1_q   <= 1'b0;
            video_p1_q   <= 1'b0;
            hsync_p1_q   <= 1'b1;
            vsync_p1_q   <= 1'b1;
            pixel_on_q   <= 1'b0;
            rgb_q        <= 12'h000;
            hsync_p2_q   <= 1'b1;
            vsync_p2_q   <= 1'b1;
            video_p2_q   <= 1'b0;
        end else begin
            text_q       <= text_d;
            upd_ack_q    <= upd_ack_d;
            vsync_prev_q <= vsync_in;
            col_p1_q     <= col_p1_d;
            in_box_p1_q  <= in_box_p1_d;
            blank_p1_q   <= blank_p1_d;
            video_p1_q   <= video_p1_d;
            hsync_p1_q   <= hsync_p1_d;
            vsync_p1_q   <= vsync_p1_d;
            pixel_on_q   <= pixel_on_d;
            rgb_q        <= rgb_d;
            hsync_p2_q   <= hsync_p2_d;
            vsync_p2_q   <= vsync_p2_d;
            video_p2_q   <= video_p2_d;
        end
    end

    assign upd_ack      = upd_ack_q;
    assign pixel_on     = pixel_on_q;
    assign rgb          = rgb_q;
    assign hsync_out    = hsync_p2_q;
    assign vsync_out    = vsync_p2_q;
    assign video_on_out = video_p2_q;

endmodule

// File: tb/tb_glyph_renderer.sv
// Directed bench for glyph_renderer with a behavioural font ROM (1-cycle read latency).
module tb_glyph_renderer;

    localparam logic [9:0]  X0 = 10'd64;
    localparam logic [9:0]  Y0 = 10'd64;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync_in, vsync_in;
    logic [7:0]  text_in;
    logic        upd_req, upd_ack;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic        pixel_on;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, video_on_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    glyph_renderer #(.NUM_CHARS(4), .X0(X0), .Y0(Y0), .FG_RGB(FG), .BG_RGB(BG)) dut (
        .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .text_in(text_in), .upd_req(upd_req), .upd_ack(upd_ack),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel_on(pixel_on), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out)
    );

    // Font contents: the blank-code rows read as all ones so forced blanking is visible.
    function automatic logic [31:0] rom_fn(input logic [6:0] a);
        case (a[6:5])
            2'd0:    rom_fn = (a[4:0] == 5'd0) ? 32'h7FFF_FFC0 : 32'h0000_FFFF;
            2'd1:    rom_fn = (a[4:0] == 5'd4) ? 32'h7C00_0000 : 32'h8000_0001;
            default: rom_fn = 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sweep 32 pixels of one row; output for input i appears two falling edges later.
    task automatic sweep(input logic [9:0] xs, input logic [9:0] y, input logic [31:0] word,
                         input logic [6:0] addr, input string tag);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk({tag, "_pix"}, 32'(pixel_on), 32'(word[33-i]));
                chk({tag, "_rgb"}, 32'(rgb), word[33-i] ? 32'(FG) : 32'(BG));
            end
            pixel_x = xs + 10'(i);
            pixel_y = y;
            if (i < 32) begin
                #1;
                chk({tag, "_addr"}, 32'(rom_addr), 32'(addr));
            end
        end
    endtask

    task automatic pt(input logic [9:0] x, input logic [9:0] y, input logic vid,
                      input logic exp_pix, input logic [11:0] exp_rgb, input string tag);
        @(negedge clk);
        pixel_x  = x;
        pixel_y  = y;
        video_on = vid;
        repeat (2) @(negedge clk);
        chk({tag, "_pix"}, 32'(pixel_on), 32'(exp_pix));
        chk({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        video_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b1;
        pixel_x  = 10'd0;
        pixel_y  = 10'd0;
        video_on = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        text_in  = 8'h00;
        upd_req  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_pix",   32'(pixel_on), 32'd0);
        chk("rst_rgb",   32'(rgb), 32'd0);
        chk("rst_hs",    32'(hsync_out), 32'd1);
        chk("rst_vs",    32'(vsync_out), 32'd1);
        chk("rst_vid",   32'(video_on_out), 32'd0);
        chk("rst_ack",   32'(upd_ack), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Request raised mid-frame: glyphs stay blank and no ack until vsync falls
        text_in = 8'hB4;
        upd_req = 1'b1;
        sweep(X0, Y0, 32'h0, 7'h60, "preload");
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_midframe", 32'(upd_ack), 32'd0);
        end
        vsync_in = 1'b0;
        @(negedge clk);
        chk("ack_pulse", 32'(upd_ack), 32'd1);
        upd_req = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(upd_ack), 32'd0);
        chk("vs_delay", 32'(vsync_out), 32'd0);
        vsync_in = 1'b1;

        sweep(X0, Y0, 32'h7FFF_FFC0, 7'h00, "code0_row0");
        sweep(X0 + 10'd32, Y0 + 10'd4, 32'h7C00_0000, 7'h24, "code1_row4");
        sweep(X0 + 10'd64, Y0, 32'h0, 7'h60, "blank_r0");
        sweep(X0 + 10'd64, Y0 + 10'd17, 32'h0, 7'h71, "blank_r17");
        sweep(X0 + 10'd64, Y0 + 10'd31, 32'h0, 7'h7F, "blank_r31");
        sweep(X0 + 10'd96, Y0, 32'hFFFF_FFFF, 7'h40, "code2_row0");

        pt(X0 - 10'd1,   Y0,          1'b1, 1'b0, BG,      "left_edge");
        pt(X0 + 10'd128, Y0,          1'b1, 1'b0, BG,      "right_edge");
        @(negedge clk);
        #1 chk("outbox_addr", 32'(rom_addr), 32'h00);
        pt(X0 + 10'd127, Y0,          1'b1, 1'b1, FG,      "last_col");
        pt(X0,           Y0 - 10'd1,  1'b1, 1'b0, BG,      "above_box");
        pt(X0 + 10'd1,   Y0 + 10'd32, 1'b1, 1'b0, BG,      "below_box");
        pt(X0 + 10'd1,   Y0,          1'b0, 1'b0, 12'h000, "video_off");
        pt(X0 + 10'd1,   Y0,          1'b1, 1'b1, FG,      "lit_pre_rst");

        // Reset mid-line with a pending request that must survive by its level
        text_in = 8'h00;
        upd_req = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_pix", 32'(pixel_on), 32'd0);
        chk("midrst_rgb", 32'(rgb), 32'd0);
        chk("midrst_hs",  32'(hsync_out), 32'd1);
        chk("midrst_vs",  32'(vsync_out), 32'd1);
        chk("midrst_ack", 32'(upd_ack), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_after_rst", 32'(upd_ack), 32'd0);
        end
        pt(X0 + 10'd65, Y0, 1'b1, 1'b0, BG, "blank_after_rst");
        vsync_in = 1'b0;
        @(negedge clk);
        chk("ack_after_rst", 32'(upd_ack), 32'd1);
        @(negedge clk);
        chk("no_reack", 32'(upd_ack), 32'd0);
        upd_req  = 1'b0;
        vsync_in = 1'b1;
        text_in  = 8'hFF;
        pt(X0 + 10'd65, Y0, 1'b1, 1'b1, FG, "loaded_after_rst");
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        chk("no_ack_without_req", 32'(upd_ack), 32'd0);
        vsync_in = 1'b1;
        pt(X0 + 10'd65, Y0, 1'b1, 1'b1, FG, "text_held");

        // 96-cycle hsync pulse reproduced two cycles later; video_on follows the same delay
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hs_pulse", 32'(hsync_out), ((i - 2 >= 0) && (i - 2 < 96)) ? 32'd0 : 32'd1);
            chk("vid_delay", 32'(video_on_out), ((i - 2 >= 10) && (i - 2 < 20)) ? 32'd0 : 32'd1);
            hsync_in = (i < 96) ? 1'b0 : 1'b1;
            video_on = ((i >= 10) && (i < 20)) ? 1'b0 : 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
